// File: rtl/addr_map_stream.sv
// ============================================================================
//  Module   : addr_map_stream
//  Purpose  : Maps a flat start address to (bramnum, bramaddr) with two
//             sequential restoring dividers, then streams a burst of words.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module addr_map_stream #(
  parameter int ADDR_W  = 15,
  parameter int INFO    = 30,
  parameter int NUM_A   = 480,
  parameter int NUM_B   = 240,
  parameter int BNUM_W  = 5,
  parameter int BADDR_W = 11,
  parameter int LEN_W   = 10,
  parameter int REM_W   = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic               req_mode,
  input  logic [LEN_W-1:0]   req_len,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BNUM_W-1:0]  out_bramnum,
  output logic [BADDR_W-1:0] out_bramaddr,
  output logic               out_last,
  output logic               ovf
);

  // Base needs one bit beyond ADDR_W so bursts running past the top keep counting.
  localparam int BASE_W = ADDR_W + 1;
  localparam int REM_W1 = REM_W + 1;
  localparam int CNT_W  = $clog2((ADDR_W > REM_W ? ADDR_W : REM_W) + 1);

  localparam logic [REM_W:0]      NUM_A_D     = REM_W1'(NUM_A);
  localparam logic [REM_W:0]      NUM_B_D     = REM_W1'(NUM_B);
  localparam logic [REM_W:0]      INFO_D      = REM_W1'(INFO);
  localparam logic [REM_W-1:0]    INFO_Z      = REM_W'(INFO);
  localparam logic [BASE_W-1:0]   INFO_B      = BASE_W'(INFO);
  localparam logic [BNUM_W-1:0]   JMAX_A      = BNUM_W'(NUM_A / INFO);
  localparam logic [BNUM_W-1:0]   JMAX_B      = BNUM_W'(NUM_B / INFO);
  localparam logic [CNT_W-1:0]    STEP_I_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]    STEP_J_LAST = CNT_W'(REM_W - 1);
  localparam logic [LEN_W-1:0]    LEN_ONE     = LEN_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV_I  = 2'd1,
    DIV_J  = 2'd2,
    STREAM = 2'd3
  } state_t;

  state_t r_state, w_state_next;

  logic                r_mode;
  logic [LEN_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_step;
  logic [ADDR_W-1:0]   r_dvd;
  logic [ADDR_W-1:0]   r_quo;
  logic [REM_W-1:0]    r_rem;
  logic [BASE_W-1:0]   r_base;
  logic [BNUM_W-1:0]   r_j;
  logic [REM_W-1:0]    r_z;
  logic                r_ovf;

  logic [REM_W:0]      w_divisor;
  logic [REM_W:0]      w_shift;
  logic                w_ge;
  logic [REM_W-1:0]    w_rem_next;
  logic [ADDR_W-1:0]   w_quo_step;
  logic [BASE_W-1:0]   w_prod;
  logic [BASE_W-1:0]   w_addr_full;
  logic                w_fire;
  logic                w_last;
  logic [REM_W-1:0]    w_z_inc;
  logic [BNUM_W-1:0]   w_j_inc;
  logic [BNUM_W-1:0]   w_jmax;

  // One restoring-division step, shared by both division phases.
  assign w_divisor   = (r_state == DIV_I) ? (r_mode ? NUM_A_D : NUM_B_D) : INFO_D;
  assign w_shift     = {r_rem, r_dvd[ADDR_W-1]};
  assign w_ge        = (w_shift >= w_divisor);
  assign w_rem_next  = w_ge ? REM_W'(w_shift - w_divisor) : w_shift[REM_W-1:0];
  assign w_quo_step  = {r_quo[ADDR_W-2:0], w_ge};
  assign w_prod      = BASE_W'(w_quo_step) * INFO_B;

  assign w_addr_full = r_base + BASE_W'(r_z);
  assign w_fire      = (r_state == STREAM) && out_ready;
  assign w_last      = (r_cnt == LEN_ONE);
  assign w_z_inc     = r_z + 1'b1;
  assign w_j_inc     = r_j + 1'b1;
  assign w_jmax      = r_mode ? JMAX_A : JMAX_B;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_bramnum  = '0;
    out_bramaddr = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_next = DIV_I;
      end
      DIV_I: if (r_step == STEP_I_LAST) w_state_next = DIV_J;
      DIV_J: if (r_step == STEP_J_LAST) w_state_next = STREAM;
      STREAM: begin
        out_valid    = 1'b1;
        out_last     = w_last;
        out_bramnum  = r_j;
        out_bramaddr = w_addr_full[BADDR_W-1:0];
        if (w_fire && w_last) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= 1'b0;
      r_cnt  <= '0;
      r_step <= '0;
      r_dvd  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_base <= '0;
      r_j    <= '0;
      r_z    <= '0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_mode <= req_mode;
            r_cnt  <= (req_len == '0) ? LEN_ONE : req_len;
            r_dvd  <= req_addr;
            r_rem  <= '0;
            r_quo  <= '0;
            r_step <= '0;
          end
        end
        DIV_I: begin
          if (r_step == STEP_I_LAST) begin
            // Quotient i becomes base; remainder r is reloaded as the next dividend.
            r_base <= w_prod;
            r_dvd  <= {w_rem_next, {(ADDR_W-REM_W){1'b0}}};
            r_rem  <= '0;
            r_quo  <= '0;
            r_step <= '0;
          end else begin
            r_dvd  <= r_dvd << 1;
            r_rem  <= w_rem_next;
            r_quo  <= w_quo_step;
            r_step <= r_step + 1'b1;
          end
        end
        DIV_J: begin
          if (r_step == STEP_J_LAST) begin
            r_j <= w_quo_step[BNUM_W-1:0];
            r_z <= w_rem_next;
          end else begin
            r_dvd  <= r_dvd << 1;
            r_rem  <= w_rem_next;
            r_quo  <= w_quo_step;
            r_step <= r_step + 1'b1;
          end
        end
        STREAM: begin
          if (w_fire) begin
            if (w_addr_full[BASE_W-1:BADDR_W] != '0) r_ovf <= 1'b1;
            if (!w_last) begin
              r_cnt <= r_cnt - 1'b1;
              if (w_z_inc == INFO_Z) begin
                r_z <= '0;
                if (w_j_inc == w_jmax) begin
                  r_j    <= '0;
                  r_base <= r_base + INFO_B;
                end else begin
                  r_j <= w_j_inc;
                end
              end else begin
                r_z <= w_z_inc;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ovf = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_addr_map_stream.sv
// ============================================================================
//  Module   : tb_addr_map_stream
//  Purpose  : Directed self-checking bench for addr_map_stream.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_addr_map_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [14:0] req_addr = '0;
  logic        req_mode = 1'b0;
  logic [9:0]  req_len = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_bramnum;
  logic [10:0] out_bramaddr;
  logic        out_last;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  always #5 clk = ~clk;

  addr_map_stream dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_mode     (req_mode),
    .req_len      (req_len),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bramnum  (out_bramnum),
    .out_bramaddr (out_bramaddr),
    .out_last     (out_last),
    .ovf          (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request at the negedge; returns at cycle 1 (just after the accept edge).
  task automatic send(input logic [14:0] a, input logic m, input logic [9:0] l);
    @(negedge clk);
    req_addr  = a;
    req_mode  = m;
    req_len   = l;
    req_valid = 1'b1;
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // Counts cycles from the accept (cycle 1) until out_valid appears.
  task automatic wait_valid(input string tag);
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    check(tag, cyc, 32'd25);
  endtask

  task automatic check_word(input string tag, input int j, input int a, input bit last);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_bramnum"}, {27'd0, out_bramnum}, j);
    check({tag, "_bramaddr"}, {21'd0, out_bramaddr}, a);
    check({tag, "_last"}, {31'd0, out_last}, {31'd0, last});
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_bramnum", {27'd0, out_bramnum}, 32'd0);
    check("rst_bramaddr", {21'd0, out_bramaddr}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    tick();

    // Single word, mode 1, addr 1000: i=2 r=40 -> (1, 60+10)
    out_ready = 1'b1;
    send(15'd1000, 1'b1, 10'd1);
    check("busy_req_ready", {31'd0, req_ready}, 32'd0);
    wait_valid("t27_latency");
    check_word("t27", 1, 70, 1'b1);
    tick();
    check("t27_done_valid", {31'd0, out_valid}, 32'd0);
    check("t27_done_ready", {31'd0, req_ready}, 32'd1);
    check("t27_ovf", {31'd0, ovf}, 32'd0);

    // Four words crossing a segment and group boundary
    send(15'd238, 1'b0, 10'd4);
    wait_valid("t28_latency");
    check_word("t28_w0", 7, 28, 1'b0); tick();
    check_word("t28_w1", 7, 29, 1'b0); tick();
    check_word("t28_w2", 0, 30, 1'b0); tick();
    check_word("t28_w3", 0, 31, 1'b1); tick();
    check("t28_done_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: out_ready alternates 0/1 every cycle
    out_ready = 1'b0;
    send(15'd1000, 1'b0, 10'd3);
    wait_valid("t29_latency");
    for (int k = 0; k < 3; k++) begin
      check_word("t29_pre", 1, 130 + k, (k == 2));
      tick();
      check_word("t29_hold", 1, 130 + k, (k == 2));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("t29_done_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;

    // Top address: 32767 = 136*240+127 -> (4, 4087 mod 2048)
    send(15'd32767, 1'b0, 10'd0);
    wait_valid("t30_latency");
    check_word("t30", 4, 2039, 1'b1);
    tick();
    check("t30_ovf_set", {31'd0, ovf}, 32'd1);
    send(15'd0, 1'b1, 10'd1);
    wait_valid("t30b_latency");
    check_word("t30b", 0, 0, 1'b1);
    tick();
    check("t30_ovf_sticky", {31'd0, ovf}, 32'd1);

    // Reset in cycle 10 of DIV_I
    send(15'd500, 1'b1, 10'd1);
    repeat (9) tick();
    check("t31_mid_div_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t31_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t31_rst_ready", {31'd0, req_ready}, 32'd1);
    check("t31_rst_ovf", {31'd0, ovf}, 32'd0);
    send(15'd0, 1'b1, 10'd1);
    wait_valid("t31_latency");
    check_word("t31", 0, 0, 1'b1);
    tick();

    // req_valid held with a different request throughout computation and burst
    send(15'd238, 1'b0, 10'd2);
    req_valid = 1'b1;
    req_addr  = 15'd5;
    req_mode  = 1'b0;
    req_len   = 10'd1;
    wait_valid("t32_latency");
    check_word("t32_w0", 7, 28, 1'b0); tick();
    check("t32_ready_in_stream", {31'd0, req_ready}, 32'd0);
    check_word("t32_w1", 7, 29, 1'b1); tick();
    check("t32_ready_after_last", {31'd0, req_ready}, 32'd1);
    check("t32_valid_after_last", {31'd0, out_valid}, 32'd0);
    tick();
    req_valid = 1'b0;
    wait_valid("t32b_latency");
    check_word("t32b", 0, 5, 1'b1);
    tick();
    check("t32b_done_valid", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
